uart_tx_scheduler: RTL and testbench

//  Shares one UART TX line among NREQ byte requesters with round-robin arbitration.

---
 rtl/uart_tx_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one UART TX line among NREQ byte requesters using round-robin
// arbitration. Each granted byte is serialised as start + DBIT data bits (LSB
// first) + optional parity + stop. Bit timing comes only from the external
// 'tick' strobe: OVS ticks per start/data/parity bit, SB_TICK ticks for stop.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit (XOR of the byte) follows the data bits
//   undefined -> plain 8N1 framing, DATA goes straight to STOP
//
// Ports
//   clk     in   1            system clock
//   rst     in   1            asynchronous reset, active high
//   tick    in   1            one-clk baud strobe
//   req     in   NREQ         req[i]=1: requester i has a byte (hold until ack[i])
//   data    in   NREQ*DBIT    byte of requester i at data[i*DBIT +: DBIT]
//   ack     out  NREQ         one-clk pulse: byte of requester i latched
//   gnt_id  out  clog2(NREQ)  index of the current/last granted requester
//   busy    out  1            high from the clk after ack until done pulses
//   done    out  1            one-clk pulse at end of stop bit
//   tx      out  1            serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int NREQ    = 2,
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] data,
  output logic [NREQ-1:0]      ack,
  output logic [IW-1:0]        gnt_id,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  localparam int TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_reg, state_next;
  logic [TW-1:0]   tick_cnt_reg, tick_cnt_next;
  logic [BW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [DBIT-1:0] byte_reg, byte_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic [IW-1:0]   gnt_reg, gnt_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            tx_reg, tx_next;

  // Per-requester view of the flat data bus.
  logic [DBIT-1:0] req_data [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
      assign req_data[gi] = data[gi*DBIT +: DBIT];
    end
  endgenerate

  // Round-robin pick: first set req at or after rr_ptr_reg, wrapping.
  // Scanning offsets from highest to lowest lets the lowest offset win.
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int cand;
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  logic last_ovs;
  logic last_sb;
  assign last_ovs = tick && (tick_cnt_reg == TW'(OVS - 1));
  assign last_sb  = tick && (tick_cnt_reg == TW'(SB_TICK - 1));

  // State register plus all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      byte_reg     <= '0;
      ack_reg      <= '0;
      gnt_reg      <= '0;
      rr_ptr_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_reg     <= byte_next;
      ack_reg      <= ack_next;
      gnt_reg      <= gnt_next;
      rr_ptr_reg   <= rr_ptr_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      tx_reg       <= tx_next;
    end
  end

  // Next-state and output logic. tx is registered from the current state, so
  // the line follows the FSM by one clk: tx falls on the clk after ack and
  // every bit still spans exactly OVS tick periods.
  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_next     = byte_reg;
    ack_next      = '0;
    gnt_next      = gnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    tx_next       = 1'b1;

    case (state_reg)
      S_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        // Grant needs no tick; a tick on this clk is deliberately not counted.
        if (grant_valid) begin
          byte_next           = req_data[grant_idx];
          ack_next[grant_idx] = 1'b1;
          gnt_next            = grant_idx;
          rr_ptr_next         = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          tick_cnt_next       = '0;
          bit_cnt_next        = '0;
          state_next          = S_START;
        end
      end

      S_START: begin
        tx_next   = 1'b0;
        busy_next = 1'b1;
        if (last_ovs) begin
          tick_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = S_DATA;
        end else if (tick) begin
          tick_cnt_next = tick_cnt_reg + 1'b1;
        end
      end

      S_DATA: begin
        tx_next   = byte_reg[bit_cnt_reg];
        busy_next = 1'b1;
        if (last_ovs) begin
          tick_cnt_next = '0;
          if (bit_cnt_reg == BW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else if (tick) begin
          tick_cnt_next = tick_cnt_reg + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_next   = ^byte_reg;
        busy_next = 1'b1;
        if (last_ovs) begin
          tick_cnt_next = '0;
          state_next    = S_STOP;
        end else if (tick) begin
          tick_cnt_next = tick_cnt_reg + 1'b1;
        end
      end
`endif

      S_STOP: begin
        tx_next   = 1'b1;
        busy_next = 1'b1;
        if (last_sb) begin
          tick_cnt_next = '0;
          done_next     = 1'b1;
          busy_next     = 1'b0;
          state_next    = S_IDLE;
        end else if (tick) begin
          tick_cnt_next = tick_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign ack    = ack_reg;
  assign gnt_id = gnt_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign tx     = tx_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler (NREQ=2, DBIT=8, OVS=16, SB_TICK=16).
// Each frame is recorded tx-per-clk from the clk after ack up to done, then
// decoded against hand-computed bit positions. With UART_TX_PARITY_EN defined
// the parity frames are exercised as well.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int NREQ = 2;
  localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_LEN = 176;  // 16*(start+8 data+parity) + 16 stop
`else
  localparam int FRAME_LEN = 160;  // 16*(start+8 data) + 16 stop
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tick = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DBIT-1:0] data = '0;
  logic [NREQ-1:0]      ack;
  logic                 gnt_id;
  logic                 busy;
  logic                 done;
  logic                 tx;

  int   checks_cnt = 0;
  int   errors_cnt = 0;
  int   tick_period = 1;
  logic q[$];
  int   extra_ack;
  int   busy_low;

  uart_tx_scheduler #(
    .NREQ(NREQ), .DBIT(DBIT), .OVS(16), .SB_TICK(16)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .data(data),
    .ack(ack), .gnt_id(gnt_id), .busy(busy), .done(done), .tx(tx)
  );

  always #5 clk = ~clk;

  // Baud strobe: every clk when tick_period<=1, else one clk in tick_period.
  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (tick_period <= 1) begin
        tick = 1'b1;
      end else begin
        ph   = (ph + 1 >= tick_period) ? 0 : ph + 1;
        tick = (ph == 0);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    check("rst_gnt", gnt_id, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int maxc, output int steps);
    steps = -1;
    for (int c = 1; c <= maxc; c++) begin
      step();
      if (ack != 0) begin
        steps = c;
        break;
      end
    end
  endtask

  // Records tx after every clk from the clk after ack until done.
  task automatic capture(input int maxc, output int len);
    q.delete();
    extra_ack = 0;
    busy_low  = 0;
    len       = -1;
    for (int c = 1; c <= maxc; c++) begin
      step();
      q.push_back(tx);
      if (done) begin
        len = c;
        break;
      end
      if (ack != 0) extra_ack++;
      if (!busy) busy_low++;
    end
    check("frame_done_seen", (len > 0), 1);
    check("frame_extra_ack", extra_ack, 0);
    check("frame_busy_gap", busy_low, 0);
    check("done_busy_clear", busy, 0);
    check("done_no_grant", ack, 0);
  endtask

  // Data bit i is sampled in the middle of its 16-clk slot (tick every clk).
  task automatic decode(output logic [7:0] b, output logic start_bit, output logic par_bit);
    b = 8'hxx;
    start_bit = 1'bx;
    par_bit = 1'bx;
    if (q.size() >= FRAME_LEN) begin
      start_bit = q[8];
      for (int i = 0; i < 8; i++) b[i] = q[16 + 16*i + 8];
      par_bit = q[152];
    end
  endtask

  initial begin : main
    int st;
    int len;
    int acks;
    logic [7:0] b;
    logic sb;
    logic pb;
    int tl[$];
    logic prev;

    // ---- Test 1: tick every clk, requester 0 sends A5 ----------------------
    tick_period = 1;
    do_reset();
    data = {8'h00, 8'hA5};
    req  = 2'b01;
    wait_ack(10, st);
    check("t1_ack_latency", st, 1);
    check("t1_ack", ack, 2'b01);
    check("t1_gnt", gnt_id, 0);
    req  = 2'b00;
    data = '0;  // must not disturb the latched byte
    capture(400, len);
    decode(b, sb, pb);
    check("t1_len", len, FRAME_LEN);
    check("t1_start", sb, 0);
    check("t1_byte", b, 8'hA5);
    check("t1_stop", (q.size() >= FRAME_LEN) ? q[FRAME_LEN-8] : 1'bx, 1);
    $display("frame t1 gnt=0 byte=%02h len=%0d", b, len);
    acks = 0;
    repeat (5) begin
      step();
      if (ack != 0) acks++;
    end
    check("t1_no_spurious_ack", acks, 0);

    // ---- Test 4: tick every 55 clks, byte 55 ------------------------------
    tick_period = 55;
    data = {8'h00, 8'h55};
    req  = 2'b01;
    wait_ack(10, st);
    check("t4_ack_latency", st, 1);
    req = 2'b00;
    capture(20000, len);
    tl.delete();
    prev = 1'b1;
    foreach (q[j]) begin
      if (q[j] !== prev) tl.push_back(j);
      prev = q[j];
    end
    check("t4_edges", tl.size(), 10);
    if (tl.size() >= 10) begin
      for (int k = 1; k <= 8; k++) check($sformatf("t4_bit%0d_width", k-1), tl[k+1] - tl[k], 880);
      check("t4_stop_width", len - tl[9], 880);
    end
    $display("frame t4 gnt=0 len=%0d edges=%0d", len, tl.size());

    // ---- Tests 2/3: both requesters held, grants alternate ----------------
    tick_period = 1;
    do_reset();
    data = {8'h22, 8'h11};
    req  = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_ack(200, st);
      check($sformatf("t3_gap_%0d", f), st, 1);
      check($sformatf("t3_ack_%0d", f), ack, (f % 2 == 1) ? 2'b10 : 2'b01);
      check($sformatf("t3_gnt_%0d", f), gnt_id, f % 2);
      capture(400, len);
      if (f == 3) req = 2'b00;
      decode(b, sb, pb);
      check($sformatf("t3_len_%0d", f), len, FRAME_LEN);
      check($sformatf("t3_byte_%0d", f), b, (f % 2 == 1) ? 8'h22 : 8'h11);
      $display("frame t3 idx=%0d gnt=%0d byte=%02h len=%0d", f, f % 2, b, len);
    end

    // ---- Test 5: async reset in the middle of DATA ------------------------
    step();
    data = {8'h00, 8'h3C};
    req  = 2'b01;
    wait_ack(10, st);
    check("t5_ack", ack, 2'b01);
    req = 2'b00;
    repeat (40) step();
    #2;
    rst = 1'b1;
    #1;
    check("t5_tx_idle", tx, 1);
    check("t5_busy_clear", busy, 0);
    acks = 0;
    repeat (3) begin
      step();
      if (done) acks++;
    end
    check("t5_no_done", acks, 0);
    @(negedge clk);
    rst  = 1'b0;
    data = {8'h22, 8'h11};
    req  = 2'b11;
    wait_ack(10, st);
    check("t5_rr_ack", ack, 2'b01);
    check("t5_rr_gnt", gnt_id, 0);
    req = 2'b00;
    capture(400, len);
    decode(b, sb, pb);
    check("t5_byte", b, 8'h11);
    $display("frame t5 gnt=0 byte=%02h len=%0d", b, len);

`ifdef UART_TX_PARITY_EN
    // ---- Test 6: even parity ----------------------------------------------
    step();
    data = {8'h00, 8'h07};
    req  = 2'b01;
    wait_ack(10, st);
    req = 2'b00;
    capture(400, len);
    decode(b, sb, pb);
    check("t6_byte_07", b, 8'h07);
    check("t6_par_07", pb, 1);
    $display("frame t6 byte=%02h parity=%0b len=%0d", b, pb, len);
    step();
    data = {8'h00, 8'h03};
    req  = 2'b01;
    wait_ack(10, st);
    req = 2'b00;
    capture(400, len);
    decode(b, sb, pb);
    check("t6_byte_03", b, 8'h03);
    check("t6_par_03", pb, 0);
    $display("frame t6 byte=%02h parity=%0b len=%0d", b, pb, len);
`endif

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
